nibble_byte_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the 8-bit nibble shift register (4-bit shift-in, 8-bit parallel out) between two nibble requesters. It grants one requester per byte transaction and drives the shift register's shift enable and nibble input for exactly two shifts. It then presents the assembled byte on a valid/ready output port, tagged with its source. A per-nibble timeout releases the grant if a requester stalls mid-byte.

---
 rtl/nibble_byte_arbiter.sv | 136 +++++++++++++
 tb/tb_nibble_byte_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_byte_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : nibble_byte_arbiter
// Brief   : Round-robin arbiter/sequencer sharing an external 8-bit nibble
//           shift register between two nibble requesters. Each granted
//           transaction shifts exactly two nibbles and then presents the
//           assembled byte on a valid/ready port tagged with its source.
//           A stalled requester is aborted after TIMEOUT idle cycles.
// Revision: 1.0 - initial release
// ============================================================================
module nibble_byte_arbiter #(
  parameter int unsigned TIMEOUT = 16  // legal range 1..255
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       req0_valid_i,
  input  logic [3:0] req0_nib_i,
  output logic       req0_ready_o,
  input  logic       req1_valid_i,
  input  logic [3:0] req1_nib_i,
  output logic       req1_ready_o,
  output logic       sr_shift_en_o,
  output logic [3:0] sr_data_in_o,
  input  logic [7:0] sr_data_out_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_data_o,
  output logic       byte_src_o,
  input  logic       byte_ready_i,
  output logic       err_timeout_o,
  output logic       err_src_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NIB0 = 2'd1,
    NIB1 = 2'd2,
    OUT  = 2'd3
  } state_e;

  // Counter value on the last tolerated stall cycle; a stall here aborts.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic       grant_q, grant_d;
  logic       prio_q,  prio_d;
  logic [7:0] cnt_q,   cnt_d;
  logic       err_q,   err_d;
  logic       err_src_q, err_src_d;

  logic       w_in_nib;
  logic       w_gnt_valid;
  logic [3:0] w_gnt_nib;
  logic       w_hs;

  // Granted requester's offer, and whether it is accepted this cycle
  assign w_in_nib    = (state_q == NIB0) || (state_q == NIB1);
  assign w_gnt_valid = grant_q ? req1_valid_i : req0_valid_i;
  assign w_gnt_nib   = grant_q ? req1_nib_i   : req0_nib_i;
  assign w_hs        = w_in_nib && w_gnt_valid;

  assign req0_ready_o  = w_in_nib && !grant_q;
  assign req1_ready_o  = w_in_nib &&  grant_q;
  assign sr_shift_en_o = w_hs;
  assign sr_data_in_o  = w_hs ? w_gnt_nib : 4'h0;

  // Byte port is driven only while the assembled byte is being offered
  assign byte_valid_o = (state_q == OUT);
  assign byte_data_o  = byte_valid_o ? sr_data_out_i : 8'h00;
  assign byte_src_o   = byte_valid_o && grant_q;

  assign err_timeout_o = err_q;
  assign err_src_o     = err_src_q;

  // Next-state logic: arbitration, nibble sequencing and stall timeout
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    prio_d    = prio_q;
    cnt_d     = cnt_q;
    err_d     = 1'b0;
    err_src_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0_valid_i || req1_valid_i) begin
          // prio breaks ties; otherwise the only valid requester wins
          grant_d = (req0_valid_i && req1_valid_i) ? prio_q : req1_valid_i;
          cnt_d   = 8'h00;
          state_d = NIB0;
        end
      end
      NIB0, NIB1: begin
        if (w_hs) begin
          // An accepted nibble always wins over an expiring counter
          cnt_d   = 8'h00;
          state_d = (state_q == NIB0) ? NIB1 : OUT;
        end else if (cnt_q == TO_LAST) begin
          err_d     = 1'b1;
          err_src_d = grant_q;
          prio_d    = ~grant_q;
          cnt_d     = 8'h00;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      OUT: begin
        if (byte_ready_i) begin
          prio_d  = ~grant_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered-output update; reset abandons any transaction
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      grant_q   <= 1'b0;
      prio_q    <= 1'b0;
      cnt_q     <= 8'h00;
      err_q     <= 1'b0;
      err_src_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      prio_q    <= prio_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      err_src_q <= err_src_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nibble_byte_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_nibble_byte_arbiter
// Brief   : Directed self-checking bench for nibble_byte_arbiter with a
//           behavioural model of the shared nibble shift register.
// Revision: 1.0 - initial release
// ============================================================================
module tb_nibble_byte_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req0_valid, req1_valid;
  logic [3:0] req0_nib, req1_nib;
  logic [3:0] nib0_m, nib1_m;
  logic       req0_ready, req1_ready;
  logic       sr_shift_en;
  logic [3:0] sr_data_in;
  logic [7:0] sr_q;
  logic       byte_valid, byte_src, byte_ready;
  logic [7:0] byte_data;
  logic       err_timeout, err_src;

  logic       auto_mode;
  logic       r0_ph, r1_ph;

  int n_checks = 0;
  int n_errs   = 0;

  nibble_byte_arbiter #(.TIMEOUT(4)) u_dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req0_valid_i (req0_valid),
    .req0_nib_i   (req0_nib),
    .req0_ready_o (req0_ready),
    .req1_valid_i (req1_valid),
    .req1_nib_i   (req1_nib),
    .req1_ready_o (req1_ready),
    .sr_shift_en_o(sr_shift_en),
    .sr_data_in_o (sr_data_in),
    .sr_data_out_i(sr_q),
    .byte_valid_o (byte_valid),
    .byte_data_o  (byte_data),
    .byte_src_o   (byte_src),
    .byte_ready_i (byte_ready),
    .err_timeout_o(err_timeout),
    .err_src_o    (err_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shift register model: new nibble enters the top, so two shifts give
  // {second, first}
  initial sr_q = 8'h00;
  always @(posedge clk) if (sr_shift_en) sr_q <= {sr_data_in, sr_q[7:4]};

  // Auto requesters: req0 offers 1 then 2, req1 offers 3 then 4
  always @(posedge clk) begin
    if (!auto_mode) begin
      r0_ph <= 1'b0;
      r1_ph <= 1'b0;
    end else begin
      if (req0_valid && req0_ready) r0_ph <= ~r0_ph;
      if (req1_valid && req1_ready) r1_ph <= ~r1_ph;
    end
  end
  assign req0_nib = auto_mode ? (r0_ph ? 4'h2 : 4'h1) : nib0_m;
  assign req1_nib = auto_mode ? (r1_ph ? 4'h4 : 4'h3) : nib1_m;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then let logic settle
  task automatic cyc(input logic v0, input logic [3:0] n0, input logic v1,
                     input logic [3:0] n1, input logic br);
    @(negedge clk);
    req0_valid = v0;
    nib0_m     = n0;
    req1_valid = v1;
    nib1_m     = n1;
    byte_ready = br;
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_rdy0"}, 32'(req0_ready), 0);
    check_eq({tag, "_rdy1"}, 32'(req1_ready), 0);
    check_eq({tag, "_shen"}, 32'(sr_shift_en), 0);
    check_eq({tag, "_sdin"}, 32'(sr_data_in), 0);
    check_eq({tag, "_bval"}, 32'(byte_valid), 0);
    check_eq({tag, "_bdat"}, 32'(byte_data), 0);
    check_eq({tag, "_bsrc"}, 32'(byte_src), 0);
    check_eq({tag, "_err"},  32'(err_timeout), 0);
    check_eq({tag, "_esrc"}, 32'(err_src), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; auto_mode = 1'b0;
    req0_valid = 0; req1_valid = 0; nib0_m = 0; nib1_m = 0; byte_ready = 1;

    // Reset state (valid requests present must not leak through)
    cyc(1, 4'h5, 1, 4'h3, 1);
    cyc(1, 4'h5, 1, 4'h3, 1);
    check_all_zero("reset");
    cyc(0, 0, 0, 0, 1);
    rst_n = 1'b1;

    // Single byte from req0: 0x5 then 0xA -> 0xA5
    cyc(1, 4'h5, 0, 0, 1);
    check_eq("t1_idle_rdy0", 32'(req0_ready), 0);
    cyc(1, 4'h5, 0, 0, 1);
    check_eq("t1_n0_rdy0", 32'(req0_ready), 1);
    check_eq("t1_n0_shen", 32'(sr_shift_en), 1);
    check_eq("t1_n0_sdin", 32'(sr_data_in), 32'h5);
    cyc(1, 4'hA, 0, 0, 1);
    check_eq("t1_n1_rdy0", 32'(req0_ready), 1);
    check_eq("t1_n1_sdin", 32'(sr_data_in), 32'hA);
    cyc(0, 0, 0, 0, 1);
    check_eq("t1_out_bval", 32'(byte_valid), 1);
    check_eq("t1_out_bdat", 32'(byte_data), 32'hA5);
    check_eq("t1_out_bsrc", 32'(byte_src), 0);
    check_eq("t1_out_shen", 32'(sr_shift_en), 0);
    check_eq("t1_out_sdin", 32'(sr_data_in), 0);
    cyc(0, 0, 0, 0, 1);
    check_eq("t1_idle_bval", 32'(byte_valid), 0);

    // Both continuously valid; prio now favours req1, so req1 goes first
    auto_mode = 1'b1;
    for (int c = 0; c < 16; c++) begin
      int ph;
      int g;
      ph = c % 4;
      g  = ((c / 4) % 2 == 0) ? 1 : 0;
      cyc(1, 0, 1, 0, 1);
      check_eq($sformatf("t2_c%0d_rdy0", c), 32'(req0_ready),
               32'((ph == 1 || ph == 2) && g == 0));
      check_eq($sformatf("t2_c%0d_rdy1", c), 32'(req1_ready),
               32'((ph == 1 || ph == 2) && g == 1));
      check_eq($sformatf("t2_c%0d_bval", c), 32'(byte_valid), 32'(ph == 3));
      if (ph == 3) begin
        check_eq($sformatf("t2_c%0d_bdat", c), 32'(byte_data),
                 (g == 1) ? 32'h43 : 32'h21);
        check_eq($sformatf("t2_c%0d_bsrc", c), 32'(byte_src), 32'(g));
      end
    end
    auto_mode = 1'b0;
    cyc(0, 0, 0, 0, 1);
    check_eq("t2_end_bval", 32'(byte_valid), 0);

    // Backpressure: byte 0xC3 held 5 cycles while req1 waits
    cyc(1, 4'h3, 0, 0, 0);
    cyc(1, 4'h3, 0, 0, 0);
    check_eq("t3_n0_sdin", 32'(sr_data_in), 32'h3);
    cyc(1, 4'hC, 0, 0, 0);
    check_eq("t3_n1_sdin", 32'(sr_data_in), 32'hC);
    for (int k = 0; k < 5; k++) begin
      cyc(0, 0, 1, 4'h5, 0);
      check_eq($sformatf("t3_hold%0d_bval", k), 32'(byte_valid), 1);
      check_eq($sformatf("t3_hold%0d_bdat", k), 32'(byte_data), 32'hC3);
      check_eq($sformatf("t3_hold%0d_bsrc", k), 32'(byte_src), 0);
      check_eq($sformatf("t3_hold%0d_shen", k), 32'(sr_shift_en), 0);
      check_eq($sformatf("t3_hold%0d_rdy1", k), 32'(req1_ready), 0);
      check_eq($sformatf("t3_hold%0d_err", k), 32'(err_timeout), 0);
    end
    cyc(0, 0, 1, 4'h6, 1);
    check_eq("t3_acc_bval", 32'(byte_valid), 1);
    cyc(0, 0, 1, 4'h6, 1);
    check_eq("t3_idle_bval", 32'(byte_valid), 0);
    check_eq("t3_idle_rdy1", 32'(req1_ready), 0);

    // Timeout: req1 gives 0x6 then stalls for 4 cycles in NIB1
    cyc(0, 0, 1, 4'h6, 1);
    check_eq("t4_n0_rdy1", 32'(req1_ready), 1);
    check_eq("t4_n0_sdin", 32'(sr_data_in), 32'h6);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 0, 0, 1);
      check_eq($sformatf("t4_stall%0d_rdy1", k), 32'(req1_ready), 1);
      check_eq($sformatf("t4_stall%0d_shen", k), 32'(sr_shift_en), 0);
      check_eq($sformatf("t4_stall%0d_err", k), 32'(err_timeout), 0);
    end
    cyc(0, 0, 0, 0, 1);
    check_eq("t4_err", 32'(err_timeout), 1);
    check_eq("t4_esrc", 32'(err_src), 1);
    check_eq("t4_bval", 32'(byte_valid), 0);
    check_eq("t4_rdy1", 32'(req1_ready), 0);
    cyc(1, 4'h7, 1, 4'h9, 1);
    check_eq("t4_err_pulse", 32'(err_timeout), 0);
    cyc(1, 4'h7, 1, 4'h9, 1);
    check_eq("t4_next_rdy0", 32'(req0_ready), 1);
    check_eq("t4_next_rdy1", 32'(req1_ready), 0);
    check_eq("t4_next_sdin", 32'(sr_data_in), 32'h7);

    // Reset in NIB1 (before the second shift): outputs drop immediately
    cyc(1, 4'h8, 1, 4'h9, 1);
    check_eq("t5_n1_rdy0", 32'(req0_ready), 1);
    #1 rst_n = 1'b0;
    #1 check_all_zero("t5_rst");
    req0_valid = 0; req1_valid = 0;
    cyc(0, 0, 0, 0, 1);
    rst_n = 1'b1;
    cyc(1, 4'h7, 0, 0, 1);
    cyc(1, 4'h7, 0, 0, 1);
    check_eq("t5_n0_sdin", 32'(sr_data_in), 32'h7);
    cyc(1, 4'hC, 0, 0, 1);
    check_eq("t5_n1_sdin", 32'(sr_data_in), 32'hC);
    cyc(0, 0, 0, 0, 1);
    check_eq("t5_bval", 32'(byte_valid), 1);
    check_eq("t5_bdat", 32'(byte_data), 32'hC7);
    check_eq("t5_bsrc", 32'(byte_src), 0);

    // Handshake on the cycle the stall counter would expire
    cyc(1, 4'h1, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 0, 0, 1);
      check_eq($sformatf("t6_stall%0d_rdy0", k), 32'(req0_ready), 1);
      check_eq($sformatf("t6_stall%0d_err", k), 32'(err_timeout), 0);
    end
    cyc(1, 4'h9, 0, 0, 1);
    check_eq("t6_late_rdy0", 32'(req0_ready), 1);
    check_eq("t6_late_shen", 32'(sr_shift_en), 1);
    check_eq("t6_late_sdin", 32'(sr_data_in), 32'h9);
    cyc(1, 4'hE, 0, 0, 1);
    check_eq("t6_n1_err", 32'(err_timeout), 0);
    check_eq("t6_n1_sdin", 32'(sr_data_in), 32'hE);
    cyc(0, 0, 0, 0, 1);
    check_eq("t6_out_err", 32'(err_timeout), 0);
    check_eq("t6_out_bval", 32'(byte_valid), 1);
    check_eq("t6_out_bdat", 32'(byte_data), 32'hE9);
    cyc(0, 0, 0, 0, 1);
    check_eq("t6_idle_err", 32'(err_timeout), 0);
    check_eq("t6_idle_bval", 32'(byte_valid), 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
